// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub shared defaults and helpers.
// Slice width is derived here so stage and top agree.
package pipe_addsub_pkg;

  localparam int W_DEF      = 16;
  localparam int STAGES_DEF = 4;

  function automatic int chunk_of(input int w, input int stages);
    return w / stages;
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// slave = adder side, master = producer/consumer side.
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry_out,
    output overflow
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry_out,
    input  overflow
  );

endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the pipelined adder.
// Adds slice K with the previous stage's carry and registers everything.
module addsub_stage
  import pipe_addsub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = chunk_of(W_DEF, STAGES_DEF),
  parameter int K     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] psum,
  input  logic         cin,
  output logic         q_valid,
  output logic [W-1:0] q_a,
  output logic [W-1:0] q_b,
  output logic [W-1:0] q_sum,
  output logic         q_c
);

  localparam int LO = K * CHUNK;

  logic [CHUNK:0] s;
  logic [W-1:0]   nsum;

  always_comb begin
    s = {1'b0, a[LO +: CHUNK]}
      + {1'b0, b[LO +: CHUNK]}
      + {{CHUNK{1'b0}}, cin};
    nsum = psum;
    nsum[LO +: CHUNK] = s[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_a     <= '0;
      q_b     <= '0;
      q_sum   <= '0;
      q_c     <= 1'b0;
    end else if (en) begin
      q_valid <= valid;
      q_a     <= a;
      q_b     <= b;
      q_sum   <= nsum;
      q_c     <= s[CHUNK];
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined W-bit adder/subtractor, one CHUNK slice per stage.
// Single global enable: the whole pipe stalls when the output is held.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_addsub_if.slave   io
);

  localparam int CHUNK = chunk_of(W, STAGES);

  logic           en;
  logic [STAGES:0] v;
  logic [STAGES:0] c;
  logic [W-1:0]   av [STAGES+1];
  logic [W-1:0]   bv [STAGES+1];
  logic [W-1:0]   sv [STAGES+1];
  logic           unused_lo;

  assign en          = !v[STAGES] || io.out_ready;
  assign io.in_ready = en;

  // B is inverted up front; sub doubles as the stage-0 carry-in
  assign v[0]  = io.in_valid;
  assign av[0] = io.a;
  assign bv[0] = io.sub ? ~io.b : io.b;
  assign c[0]  = io.sub;
  assign sv[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .W     (W),
      .CHUNK (CHUNK),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .valid   (v[k]),
      .a       (av[k]),
      .b       (bv[k]),
      .psum    (sv[k]),
      .cin     (c[k]),
      .q_valid (v[k+1]),
      .q_a     (av[k+1]),
      .q_b     (bv[k+1]),
      .q_sum   (sv[k+1]),
      .q_c     (c[k+1])
    );
  end

  assign io.out_valid = v[STAGES];
  assign io.sum       = sv[STAGES];
  assign io.carry_out = c[STAGES];
  assign io.overflow  =
    (av[STAGES][W-1] == bv[STAGES][W-1]) &&
    (sv[STAGES][W-1] != av[STAGES][W-1]);

  assign unused_lo = ^{av[STAGES][W-2:0], bv[STAGES][W-2:0]};

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter W, default 16: operand and result width in bits; W SHALL be >= 2 and divisible by STAGES.
REQ-002 Parameter STAGES, default 4: pipeline depth; each stage SHALL add a slice of CHUNK = W/STAGES bits.
REQ-003 CLK  input  1  rising-edge clock, sole clock domain.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 IN_VALID  input  1  the operand set on A, B and SUB is valid.
REQ-006 IN_READY  output  1  the block accepts an operand set this cycle.
REQ-007 A  input  W  operand A, unsigned or two's-complement.
REQ-008 B  input  W  operand B.
REQ-009 SUB  input  1  0 = A+B, 1 = A-B.
REQ-010 OUT_VALID  output  1  SUM, CARRY_OUT and OVERFLOW hold a valid result.
REQ-011 OUT_READY  input  1  the consumer takes the result this cycle.
REQ-012 SUM  output  W  result modulo 2^W.
REQ-013 CARRY_OUT  output  1  carry out of bit W-1; for subtraction, 1 = no borrow.
REQ-014 OVERFLOW  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 An input transfer SHALL occur when IN_VALID && IN_READY at a rising CLK edge; an output transfer SHALL occur when OUT_VALID && OUT_READY.
REQ-016 The pipeline SHALL have one global enable, EN = !OUT_VALID || OUT_READY; IN_READY SHALL equal EN, combinationally.
REQ-017 When EN=0, every stage register, including valid bits, SHALL hold its value.
REQ-018 When EN=1, every stage SHALL advance one position; stage 0 SHALL load the valid bit IN_VALID.
REQ-019 Bubbles SHALL NOT be compressed: the block SHALL keep one slot per stage.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to OUT_VALID when EN stays 1.
REQ-021 Throughput SHALL be one operation per cycle when OUT_READY is held at 1.
REQ-022 Subtraction SHALL be computed as A + ~B + 1: B is inverted and the stage-0 carry-in is 1; for addition the stage-0 carry-in is 0.
REQ-023 Stage k SHALL add bits [k*CHUNK +: CHUNK] of A and B' with the carry registered by stage k-1.
REQ-024 Stage k SHALL register its CHUNK-bit partial sum, its carry, and the not-yet-added upper operand bits; lower result bits SHALL be delayed alongside.
REQ-025 The carry chain SHALL NOT exceed CHUNK bits between registers.
REQ-026 CARRY_OUT SHALL equal the carry out of the final stage.
REQ-027 OVERFLOW SHALL equal (A[W-1] == B'[W-1]) && (SUM[W-1] != A[W-1]), where B' is the inverted B for subtraction and B otherwise.
REQ-028 SUM, CARRY_OUT and OVERFLOW SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-029 STAGES=1 SHALL give a single registered W-bit adder with latency 1.
REQ-030 Data in invalid slots is don't-care but SHALL NOT affect valid results.

Reset
REQ-031 RST_N=0 SHALL asynchronously clear all valid bits; OUT_VALID, SUM, CARRY_OUT and OVERFLOW SHALL read 0.
REQ-032 Operations in flight at reset SHALL be discarded, with no output transfer.
REQ-033 The first accepted operation after RST_N rises SHALL complete normally.
REQ-034 IN_READY SHALL be 1 during and immediately after reset.

Structure
REQ-035 A shared package SHALL hold the default W and STAGES and a function that computes CHUNK.
REQ-036 One sub-module, addsub_stage, SHALL implement one CHUNK-bit slice with carry-in/carry-out and its registers; pipe_addsub SHALL instantiate STAGES copies with a generate loop.

Verification (W=16, STAGES=4)
REQ-037 A=0xFFFF, B=0x0001, SUB=0 -> after 4 cycles SUM=0x0000, CARRY_OUT=1, OVERFLOW=0; this checks carry ripple across all stages.
REQ-038 A=0x7FFF, B=0x0001, SUB=0 -> SUM=0x8000, CARRY_OUT=0, OVERFLOW=1; A=0x0005, B=0x0007, SUB=1 -> SUM=0xFFFE, CARRY_OUT=0, OVERFLOW=0.
REQ-039 Stream 100 random operations with OUT_READY=1 -> one result per cycle, in order, matching the reference model.
REQ-040 Hold OUT_READY=0 for 5 cycles with the pipeline full -> IN_READY=0, outputs frozen, no loss or duplication after release.
REQ-041 Assert RST_N=0 mid-stream with 3 operations in flight -> OUT_VALID=0 immediately; no stale result appears after reset.
REQ-042 Apply alternating IN_VALID with a random OUT_READY -> bubbles preserved, and the output order and values match the model.
